serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 127 ++++++++++++
 tb/tb_serial_addsub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB first, and
// reports result plus carry/sign/overflow/zero flags on a one-cycle done pulse.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             sign,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             op_q;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   sl_sum;
    logic             msb_cin;

    assign state_dbg = state;

    // Select the active slice with constant indices so every part-select is static.
    always_comb begin
        a_sl     = '0;
        b_sl     = '0;
        acc_next = acc;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_q[i*DIGIT +: DIGIT];
                b_sl = b_q[i*DIGIT +: DIGIT];
            end
        end
        b_eff   = op_q ? ~b_sl : b_sl;
        sl_sum  = {1'b0, a_sl} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cy};
        // Carry into the slice MSB recovered from its sum bit: a ^ b ^ s.
        msb_cin = a_sl[DIGIT-1] ^ b_eff[DIGIT-1] ^ sl_sum[DIGIT-1];
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                acc_next[i*DIGIT +: DIGIT] = sl_sum[DIGIT-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            sign     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            cy       <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        cy    <= op;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cy  <= sl_sum[DIGIT];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= acc_next;
                        carry    <= sl_sum[DIGIT];
                        sign     <= op_q & ~sl_sum[DIGIT];
                        overflow <= msb_cin ^ sl_sum[DIGIT];
                        zero     <= (acc_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: three instances (4x1, 8x1, 8x4) share
// clock, reset and operand buses; each has its own start strobe.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] start_v;
    logic [2:0] busy_v, done_v, carry_v, sign_v, ovf_v, zero_v;
    logic [3:0] res4;
    logic [7:0] res8, res84;
    logic [1:0] st0, st1, st2;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(4), .DIGIT(1)) u_w4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .op(op), .a(a[3:0]), .b(b[3:0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(res4), .carry(carry_v[0]),
        .sign(sign_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]), .state_dbg(st0)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .op(op), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .result(res8), .carry(carry_v[1]),
        .sign(sign_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]), .state_dbg(st1)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .op(op), .a(a), .b(b),
        .busy(busy_v[2]), .done(done_v[2]), .result(res84), .carry(carry_v[2]),
        .sign(sign_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]), .state_dbg(st2)
    );

    function automatic logic [7:0] res_of(input int w);
        case (w)
            0:       res_of = {4'h0, res4};
            1:       res_of = res8;
            default: res_of = res84;
        endcase
    endfunction

    function automatic logic [1:0] st_of(input int w);
        case (w)
            0:       st_of = st0;
            1:       st_of = st1;
            default: st_of = st2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int w, input logic [7:0] r,
                           input logic c, input logic s, input logic o, input logic z);
        chk({tag, ".result"},   res_of(w),          r);
        chk({tag, ".carry"},    {7'b0, carry_v[w]}, {7'b0, c});
        chk({tag, ".sign"},     {7'b0, sign_v[w]},  {7'b0, s});
        chk({tag, ".overflow"}, {7'b0, ovf_v[w]},   {7'b0, o});
        chk({tag, ".zero"},     {7'b0, zero_v[w]},  {7'b0, z});
    endtask

    // Steps negedges until done, bounded; counts elapsed cycles and busy cycles.
    task automatic wait_done(input int w, output int cyc, output int bc, output logic got);
        cyc = 0;
        bc  = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_v[w]) begin
                got = 1'b1;
                break;
            end
            if (busy_v[w]) bc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge; returns one negedge after the done pulse.
    task automatic run_op(input int w, input logic o, input logic [7:0] x, input logic [7:0] y,
                          input int exp_busy, input string tag);
        int   cyc;
        int   bc;
        logic got;
        op = o;
        a  = x;
        b  = y;
        start_v[w] = 1'b1;
        @(negedge clk);
        start_v[w] = 1'b0;
        wait_done(w, cyc, bc, got);
        chk({tag, ".done_seen"},   {7'b0, got}, 8'd1);
        chk({tag, ".busy_cycles"}, 8'(bc),      8'(exp_busy));
        @(negedge clk);
        chk({tag, ".done_pulse"},  {7'b0, done_v[w]}, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   bc;
        logic got;
        op      = 1'b0;
        a       = '0;
        b       = '0;
        start_v = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);

        for (int w = 0; w < 3; w++) begin
            chk_out("reset", w, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("reset.busy",  {7'b0, busy_v[w]}, 8'd0);
            chk("reset.done",  {7'b0, done_v[w]}, 8'd0);
            chk("reset.state", {6'b0, st_of(w)},  8'd0);
        end

        // Release and start on the same negedge: first edge after reset must accept.
        rst = 1'b0;
        run_op(0, 1'b1, 8'h0D, 8'h01, 4, "sub4_a");
        chk_out("sub4_a", 0, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(0, 1'b1, 8'h03, 8'h0F, 4, "sub4_b");
        chk_out("sub4_b", 0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(0, 1'b1, 8'h08, 8'h03, 4, "sub4_c");
        chk_out("sub4_c", 0, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0);

        run_op(1, 1'b0, 8'h7F, 8'h01, 8, "add8_ovf");
        chk_out("add8_ovf", 1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(1, 1'b1, 8'h5A, 8'h5A, 8, "sub8_zero");
        chk_out("sub8_zero", 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        run_op(2, 1'b0, 8'hFF, 8'h01, 2, "add8d4_wrap");
        chk_out("add8d4_wrap", 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(2, 1'b0, 8'h0F, 8'h01, 2, "add8d4_dcarry");
        chk_out("add8d4_dcarry", 2, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2, 1'b1, 8'h35, 8'h47, 2, "sub8d4_borrow");
        chk_out("sub8d4_borrow", 2, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2, 1'b1, 8'h80, 8'h01, 2, "sub8d4_ovf");
        chk_out("sub8d4_ovf", 2, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);

        // Start pulsed mid-RUN with different operands must be ignored.
        op = 1'b0; a = 8'h10; b = 8'h20; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        op = 1'b1; a = 8'hFF; b = 8'hFF; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_done(1, cyc, bc, got);
        chk("ignore.done_seen", {7'b0, got}, 8'd1);
        chk_out("ignore", 1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ignore.busy_after", {7'b0, busy_v[1]}, 8'd0);
        chk("ignore.result_hold", res8, 8'h30);

        // Start held high through DONE: next operation follows immediately.
        op = 1'b0; a = 8'h01; b = 8'h02; start_v[1] = 1'b1;
        @(negedge clk);
        wait_done(1, cyc, bc, got);
        chk("b2b.first_seen", {7'b0, got}, 8'd1);
        chk("b2b.first_result", res8, 8'h03);
        a = 8'h03; b = 8'h04;
        @(negedge clk);
        wait_done(1, cyc, bc, got);
        chk("b2b.second_seen", {7'b0, got}, 8'd1);
        chk("b2b.spacing", 8'(cyc + 1), 8'd9);
        chk("b2b.busy_cycles", 8'(bc), 8'd8);
        chk("b2b.second_result", res8, 8'h07);
        start_v[1] = 1'b0;
        @(negedge clk);
        chk("b2b.idle_busy", {7'b0, busy_v[1]}, 8'd0);
        chk("b2b.idle_done", {7'b0, done_v[1]}, 8'd0);

        // Abort at RUN cycle 2 of 4; reset acts between clock edges.
        op = 1'b0; a = 8'h03; b = 8'h04; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("abort.busy_before", {7'b0, busy_v[0]}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk_out("abort_async", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_async.busy",  {7'b0, busy_v[0]}, 8'd0);
        chk("abort_async.done",  {7'b0, done_v[0]}, 8'd0);
        chk("abort_async.state", {6'b0, st0},       8'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(0, cyc, bc, got);
        chk("abort.no_done", {7'b0, got}, 8'd0);
        chk("abort.no_busy", 8'(bc),      8'd0);
        run_op(0, 1'b0, 8'h05, 8'h06, 4, "after_abort");
        chk_out("after_abort", 0, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
